// File: rtl/rv32i_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_mem_arb
//  Purpose  : Shares one single-port unified instruction/data memory between
//             the core's fetch port (F) and load/store port (D). Round-robin
//             arbitration on conflict, address range checking, and in-order
//             fixed-latency routing of read data back to the requester.
//  Ports    : clk, rst_n (sync, active low), halt
//             F side : f_req, f_addr -> f_ready, f_rsp_valid/data/err
//             D side : d_req, d_wr, d_addr, d_wdata, d_be
//                      -> d_ready, d_rsp_valid/data/err
//             Memory : mem_req, mem_wr, mem_addr, mem_wdata, mem_be <- mem_rdata
//             Status : idle
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_mem_arb #(
    parameter logic [31:0] I_MEM_LSB = 32'h0000_0000,
    parameter logic [31:0] D_MEM_MSB = 32'h0001_FFFF,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    // fetch port
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ready,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    // load/store port
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    // memory macro
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    // status
    output logic        idle
);

    localparam logic        c_OWNER_F = 1'b0;
    localparam logic        c_OWNER_D = 1'b1;
    // Offset-based range check: an address below I_MEM_LSB wraps to a huge
    // offset and fails the single unsigned compare.
    localparam logic [31:0] c_SPAN    = D_MEM_MSB - 32'd3 - I_MEM_LSB;

    logic              r_rr_ptr;
    logic [RD_LAT-1:0] r_pv;
    logic [RD_LAT-1:0] r_po;
    logic [RD_LAT-1:0] r_pe;

    logic w_go;
    logic w_grant_f;
    logic w_grant_d;
    logic w_f_legal;
    logic w_d_legal;
    logic w_push;
    logic w_push_own;
    logic w_push_err;
    logic w_head_v;
    logic w_head_o;
    logic w_head_e;

    // ------------------------------------------------------------------
    // Arbitration: combinational, at most one grant per cycle
    // ------------------------------------------------------------------
    assign w_go      = ~halt & rst_n;
    assign w_grant_f = f_req & (~d_req | (r_rr_ptr == c_OWNER_F));
    assign w_grant_d = d_req & (~f_req | (r_rr_ptr == c_OWNER_D));
    assign f_ready   = w_grant_f & w_go;
    assign d_ready   = w_grant_d & w_go;

    assign w_f_legal = ((f_addr - I_MEM_LSB) <= c_SPAN);
    assign w_d_legal = ((d_addr - I_MEM_LSB) <= c_SPAN);

    // Pointer only moves when a conflict is actually resolved into a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= c_OWNER_D;
        end else if (f_req & d_req & ~halt) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Memory side
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = (f_ready & w_f_legal) | (d_ready & w_d_legal);
        mem_wr    = d_ready & d_wr & w_d_legal;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        if (f_ready) begin
            mem_addr = f_addr;
            mem_be   = 4'hF;
        end else if (d_ready) begin
            mem_addr = d_addr;
            if (d_wr) begin
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end else begin
                mem_be    = 4'hF;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipe: one slot per accepted read or per illegal access.
    // Legal stores are posted and occupy no slot.
    // ------------------------------------------------------------------
    assign w_push     = f_ready | (d_ready & (~d_wr | ~w_d_legal));
    assign w_push_own = d_ready ? c_OWNER_D : c_OWNER_F;
    assign w_push_err = f_ready ? ~w_f_legal : ~w_d_legal;

    generate
        if (RD_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    r_po <= '0;
                    r_pe <= '0;
                end else begin
                    r_pv <= w_push;
                    r_po <= w_push_own;
                    r_pe <= w_push_err;
                end
            end
        end else begin : g_pipe_shift
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    r_po <= '0;
                    r_pe <= '0;
                end else begin
                    r_pv <= {r_pv[RD_LAT-2:0], w_push};
                    r_po <= {r_po[RD_LAT-2:0], w_push_own};
                    r_pe <= {r_pe[RD_LAT-2:0], w_push_err};
                end
            end
        end
    endgenerate

    // Gating with rst_n keeps a pending slot from leaking out during the
    // reset cycle itself.
    assign w_head_v = r_pv[RD_LAT-1] & rst_n;
    assign w_head_o = r_po[RD_LAT-1];
    assign w_head_e = r_pe[RD_LAT-1];

    assign f_rsp_valid = w_head_v & (w_head_o == c_OWNER_F);
    assign d_rsp_valid = w_head_v & (w_head_o == c_OWNER_D);
    assign f_rsp_err   = f_rsp_valid & w_head_e;
    assign d_rsp_err   = d_rsp_valid & w_head_e;
    assign f_rsp_data  = (f_rsp_valid & ~w_head_e) ? mem_rdata : 32'h0;
    assign d_rsp_data  = (d_rsp_valid & ~w_head_e) ? mem_rdata : 32'h0;

    assign idle = ~(f_ready | d_ready) & ~((|r_pv) & rst_n);

endmodule
`default_nettype wire
